// File: rtl/pipe_stall_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Bundles the hazard inputs and pipeline-control outputs of pipe_stall_ctrl.
//   Hazards (datapath -> controller): dmem_stall, ld_use_stall, br_taken_X,
//                                     imem_stall, halt_D
//   Controls (controller -> datapath): pc_en, en_FD/DX/XM/MW, nop_FD/DX/XM,
//                                      halted, stall_cycles, flush_cycles
// Modports:
//   master - datapath side: drives hazards, consumes controls
//   slave  - controller side: consumes hazards, drives controls
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dmem_stall;
  logic             ld_use_stall;
  logic             br_taken_X;
  logic             imem_stall;
  logic             halt_D;

  logic             pc_en;
  logic             en_FD;
  logic             en_DX;
  logic             en_XM;
  logic             en_MW;
  logic             nop_FD;
  logic             nop_DX;
  logic             nop_XM;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  modport master (
    output dmem_stall, ld_use_stall, br_taken_X, imem_stall, halt_D,
    input  pc_en, en_FD, en_DX, en_XM, en_MW, nop_FD, nop_DX, nop_XM,
    input  halted, stall_cycles, flush_cycles
  );

  modport slave (
    input  dmem_stall, ld_use_stall, br_taken_X, imem_stall, halt_D,
    output pc_en, en_FD, en_DX, en_XM, en_MW, nop_FD, nop_DX, nop_XM,
    output halted, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Stall / flush / halt controller for a 5-stage in-order pipeline.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - pipe_stall_ctrl_if.slave: hazard inputs in; PC/pipeline-register
//          enables, bubble (nop_*) selects, sticky halted flag and saturating
//          stall/flush performance counters out.
// Enables and nop selects are combinational from state and inputs; halted and
// the counters are registered. HALT drains the three older instructions
// (drain_cnt 2..0) before entering HALTED, which is left only through rst.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] HALT_DRAIN = 2'd1;
  localparam logic [1:0] HALTED     = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

  logic pc_en_c, en_fd_c, en_dx_c, en_xm_c, en_mw_c;
  logic nop_fd_c, nop_dx_c, nop_xm_c;
  logic stall_inc, flush_inc;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_en_c     = 1'b0;
    en_fd_c     = 1'b0;
    en_dx_c     = 1'b0;
    en_xm_c     = 1'b0;
    en_mw_c     = 1'b0;
    nop_fd_c    = 1'b0;
    nop_dx_c    = 1'b0;
    nop_xm_c    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.dmem_stall) begin
          // Whole pipeline frozen until the M-stage access completes.
          stall_inc = 1'b1;
        end else if (bus.ld_use_stall) begin
          // Hold F/D/X, let M/W advance and push a bubble into M.
          en_xm_c   = 1'b1;
          en_mw_c   = 1'b1;
          nop_xm_c  = 1'b1;
          stall_inc = 1'b1;
        end else if (bus.br_taken_X) begin
          // Redirect PC and squash the two younger instructions in F and D.
          {pc_en_c, en_fd_c, en_dx_c, en_xm_c, en_mw_c} = 5'b11111;
          nop_fd_c  = 1'b1;
          nop_dx_c  = 1'b1;
          flush_inc = 1'b1;
        end else if (bus.imem_stall) begin
          // Older instructions keep flowing; a bubble enters D.
          {en_fd_c, en_dx_c, en_xm_c, en_mw_c} = 4'b1111;
          nop_fd_c  = 1'b1;
          stall_inc = 1'b1;
        end else if (bus.halt_D) begin
          // Stop fetching; HALT moves on and three more edges drain X/M/W.
          {en_fd_c, en_dx_c, en_xm_c, en_mw_c} = 4'b1111;
          nop_fd_c    = 1'b1;
          drain_cnt_d = 2'd2;
          state_d     = HALT_DRAIN;
        end else begin
          {pc_en_c, en_fd_c, en_dx_c, en_xm_c, en_mw_c} = 5'b11111;
        end
      end

      HALT_DRAIN: begin
        if (bus.dmem_stall) begin
          stall_inc = 1'b1;
        end else begin
          {en_fd_c, en_dx_c, en_xm_c, en_mw_c} = 4'b1111;
          nop_fd_c = 1'b1;
          if (drain_cnt_q == 2'd0) begin
            state_d = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end
      end

      HALTED: begin
        // Everything frozen; counters hold.
      end

      default: begin
        state_d = RUN;
      end
    endcase

    halted_d       = halted_q | (state_d == HALTED);
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall_inc && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (flush_inc && (flush_cycles_q != {CNT_W{1'b1}})) begin
      flush_cycles_d = flush_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      drain_cnt_q    <= 2'd0;
      halted_q       <= 1'b0;
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      halted_q       <= halted_d;
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  // Controls are forced low for the whole time rst is high, not just at the
  // edge, so the datapath never loads while the controller is being reset.
  assign bus.pc_en        = pc_en_c  & ~rst;
  assign bus.en_FD        = en_fd_c  & ~rst;
  assign bus.en_DX        = en_dx_c  & ~rst;
  assign bus.en_XM        = en_xm_c  & ~rst;
  assign bus.en_MW        = en_mw_c  & ~rst;
  assign bus.nop_FD       = nop_fd_c & ~rst;
  assign bus.nop_DX       = nop_dx_c & ~rst;
  assign bus.nop_XM       = nop_xm_c & ~rst;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_cycles = flush_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed testbench for pipe_stall_ctrl. A CNT_W=16 instance covers the
// control behaviour; a CNT_W=4 instance covers counter saturation.
// Control outputs are compared as an 8-bit vector
//   {pc_en, en_FD, en_DX, en_XM, en_MW, nop_FD, nop_DX, nop_XM}.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_stall_ctrl_if #(.CNT_W(16)) bus ();
  pipe_stall_ctrl_if #(.CNT_W(4))  sat_bus ();

  pipe_stall_ctrl #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_stall_ctrl #(.CNT_W(4)) sat_dut (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] V_RUN    = 8'b1111_1000;
  localparam logic [7:0] V_FREEZE = 8'b0000_0000;
  localparam logic [7:0] V_LDUSE  = 8'b0001_1001;
  localparam logic [7:0] V_BR     = 8'b1111_1110;
  localparam logic [7:0] V_BUBBLE = 8'b0111_1100;

  function automatic logic [7:0] ctrl_vec();
    return {bus.pc_en, bus.en_FD, bus.en_DX, bus.en_XM, bus.en_MW,
            bus.nop_FD, bus.nop_DX, bus.nop_XM};
  endfunction

  // Input order: dmem, ld_use, br, imem, halt
  task automatic set_in(input logic [4:0] v);
    bus.dmem_stall   = v[4];
    bus.ld_use_stall = v[3];
    bus.br_taken_X   = v[2];
    bus.imem_stall   = v[1];
    bus.halt_D       = v[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_in(5'b00000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(5'b11111);
    @(posedge clk);
    #2;
    checks++;
    if (ctrl_vec() !== V_FREEZE) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected %b", ctrl_vec(), V_FREEZE);
    end
    checks++;
    if ({bus.halted, bus.stall_cycles, bus.flush_cycles} !== 33'd0) begin
      failures++;
      $display("FAIL reset_regs: halted=%b stall=%0d flush=%0d expected 0/0/0",
               bus.halted, bus.stall_cycles, bus.flush_cycles);
    end
    apply_reset();
    #2;
    checks++;
    if (ctrl_vec() !== V_RUN) begin
      failures++;
      $display("FAIL first_quiet_after_reset: got %b expected %b", ctrl_vec(), V_RUN);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_in(5'b01000);
    #2;
    checks++;
    if (ctrl_vec() !== V_LDUSE) begin
      failures++;
      $display("FAIL load_use_ctrl: got %b expected %b", ctrl_vec(), V_LDUSE);
    end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL load_use_stall_before: got %0d expected 0", bus.stall_cycles);
    end
    step();
    set_in(5'b00000);
    #2;
    checks++;
    if (bus.stall_cycles !== 16'd1) begin
      failures++;
      $display("FAIL load_use_stall_after: got %0d expected 1", bus.stall_cycles);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    set_in(5'b11100);
    #2;
    checks++;
    if (ctrl_vec() !== V_FREEZE) begin
      failures++;
      $display("FAIL priority_freeze: got %b expected %b", ctrl_vec(), V_FREEZE);
    end
    step();
    set_in(5'b00100);
    #2;
    checks++;
    if (bus.stall_cycles !== 16'd1 || bus.flush_cycles !== 16'd0) begin
      failures++;
      $display("FAIL priority_counters: stall=%0d flush=%0d expected 1/0",
               bus.stall_cycles, bus.flush_cycles);
    end
    checks++;
    if (ctrl_vec() !== V_BR) begin
      failures++;
      $display("FAIL branch_flush_ctrl: got %b expected %b", ctrl_vec(), V_BR);
    end
    step();
    set_in(5'b00000);
    #2;
    checks++;
    if (bus.flush_cycles !== 16'd1) begin
      failures++;
      $display("FAIL branch_flush_count: got %0d expected 1", bus.flush_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ins [5];
    logic [7:0] exp [5];
    ins = '{5'b01000, 5'b00100, 5'b00010, 5'b10000, 5'b00000};
    exp = '{V_LDUSE,  V_BR,     V_BUBBLE, V_FREEZE, V_RUN};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(ins[c]);
      #2;
      checks++;
      if (ctrl_vec() !== exp[c]) begin
        failures++;
        $display("FAIL back_to_back_c%0d: got %b expected %b", c, ctrl_vec(), exp[c]);
      end
      if (c < 4) step();
    end
    checks++;
    if (bus.stall_cycles !== 16'd3 || bus.flush_cycles !== 16'd1) begin
      failures++;
      $display("FAIL back_to_back_counters: stall=%0d flush=%0d expected 3/1",
               bus.stall_cycles, bus.flush_cycles);
    end
  endtask

  task automatic test_halt_coincident();
    logic [4:0] ins [4];
    logic [7:0] exp [4];
    ins = '{5'b01001, 5'b00000, 5'b00101, 5'b00000};
    exp = '{V_LDUSE,  V_RUN,    V_BR,     V_RUN};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(ins[c]);
      #2;
      checks++;
      if (ctrl_vec() !== exp[c]) begin
        failures++;
        $display("FAIL halt_coincident_c%0d: got %b expected %b", c, ctrl_vec(), exp[c]);
      end
      step();
    end
  endtask

  task automatic test_halt_drain();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      logic [7:0] e_vec;
      logic       e_halt;
      if (c == 0)      set_in(5'b00001);
      else if (c == 5) set_in(5'b11111);
      else             set_in(5'b00000);
      e_vec  = (c <= 3) ? V_BUBBLE : V_FREEZE;
      e_halt = (c >= 4);
      #2;
      checks++;
      if (ctrl_vec() !== e_vec || bus.halted !== e_halt) begin
        failures++;
        $display("FAIL halt_drain_c%0d: ctrl=%b halted=%b expected %b/%b",
                 c, ctrl_vec(), bus.halted, e_vec, e_halt);
      end
      if (c < 6) step();
    end
    checks++;
    if (bus.stall_cycles !== 16'd0 || bus.flush_cycles !== 16'd0) begin
      failures++;
      $display("FAIL halted_counters_hold: stall=%0d flush=%0d expected 0/0",
               bus.stall_cycles, bus.flush_cycles);
    end
    // Asynchronous reset from HALTED, mid-cycle.
    rst = 1'b1;
    #1;
    checks++;
    if (bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL halted_async_reset: got %b expected 0", bus.halted);
    end
    step();
    rst = 1'b0;
    set_in(5'b00000);
    #2;
    checks++;
    if (ctrl_vec() !== V_RUN) begin
      failures++;
      $display("FAIL run_after_halted_reset: got %b expected %b", ctrl_vec(), V_RUN);
    end
  endtask

  task automatic test_halt_dmem();
    logic [4:0] ins [8];
    logic [7:0] exp [8];
    ins = '{5'b00001, 5'b00100, 5'b10000, 5'b10000, 5'b10000,
            5'b00000, 5'b00000, 5'b00000};
    exp = '{V_BUBBLE, V_BUBBLE, V_FREEZE, V_FREEZE, V_FREEZE,
            V_BUBBLE, V_BUBBLE, V_FREEZE};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(ins[c]);
      #2;
      checks++;
      if (ctrl_vec() !== exp[c] || bus.halted !== (c == 7)) begin
        failures++;
        $display("FAIL halt_dmem_c%0d: ctrl=%b halted=%b expected %b/%b",
                 c, ctrl_vec(), bus.halted, exp[c], (c == 7));
      end
      if (c < 7) step();
    end
    checks++;
    if (bus.stall_cycles !== 16'd3 || bus.flush_cycles !== 16'd0) begin
      failures++;
      $display("FAIL halt_dmem_counters: stall=%0d flush=%0d expected 3/0",
               bus.stall_cycles, bus.flush_cycles);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    set_in(5'b10000);  // one stall so the counter is non-zero
    step();
    set_in(5'b00001);  // HALT accepted
    step();
    set_in(5'b00000);  // drain cycle 1
    step();
    #2;                // drain cycle 2
    checks++;
    if (ctrl_vec() !== V_BUBBLE || bus.stall_cycles !== 16'd1) begin
      failures++;
      $display("FAIL mid_drain_pre_reset: ctrl=%b stall=%0d expected %b/1",
               ctrl_vec(), bus.stall_cycles, V_BUBBLE);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== V_FREEZE || bus.halted !== 1'b0 || bus.stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL mid_drain_async_reset: ctrl=%b halted=%b stall=%0d expected %b/0/0",
               ctrl_vec(), bus.halted, bus.stall_cycles, V_FREEZE);
    end
    step();
    rst = 1'b0;
    #2;
    checks++;
    if (ctrl_vec() !== V_RUN) begin
      failures++;
      $display("FAIL mid_drain_run_after: got %b expected %b", ctrl_vec(), V_RUN);
    end
    step();
    step();
    step();
    checks++;
    if (bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL mid_drain_no_halt: got %b expected 0", bus.halted);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    sat_bus.imem_stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        checks++;
        if (sat_bus.stall_cycles !== 4'd14) begin
          failures++;
          $display("FAIL sat_counting: got %0d expected 14", sat_bus.stall_cycles);
        end
      end
    end
    checks++;
    if (sat_bus.stall_cycles !== 4'd15 || sat_bus.flush_cycles !== 4'd0) begin
      failures++;
      $display("FAIL sat_hold: stall=%0d flush=%0d expected 15/0",
               sat_bus.stall_cycles, sat_bus.flush_cycles);
    end
    sat_bus.imem_stall = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_in(5'b00000);
    sat_bus.dmem_stall   = 1'b0;
    sat_bus.ld_use_stall = 1'b0;
    sat_bus.br_taken_X   = 1'b0;
    sat_bus.imem_stall   = 1'b0;
    sat_bus.halt_D       = 1'b0;

    test_reset();
    test_load_use();
    test_priority();
    test_back_to_back();
    test_halt_coincident();
    test_halt_drain();
    test_halt_dmem();
    test_reset_mid_drain();
    test_saturation();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
